// File: rtl/rc5_pkg.sv
// Shared RC5-32/12/16 definitions: word and table sizes, magic constants,
// the controller state encoding and the data-dependent rotate.
package rc5_pkg;

  localparam int W = 32;
  localparam int R = 12;
  localparam int T = 2 * (R + 1);
  localparam int C = 4;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } rc5_state_t;

  // The upper half of a doubled word shifted left is the rotated word.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {x, x} << amt;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] s_init(input int unsigned idx);
    return P32 + 32'(idx) * Q32;
  endfunction

endpackage

// File: rtl/rc5_mix_step.sv
// One RC5 key-schedule mixing iteration: new A from S[i], new B from L[j].
module rc5_mix_step
  import rc5_pkg::*;
(
  input  logic [31:0] s_i,
  input  logic [31:0] l_j,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] a_next,
  output logic [31:0] b_next
);

  logic [31:0] ab_sum;

  always_comb begin
    a_next = rotl32(s_i + a + b, 5'd3);
    ab_sum = a_next + b;
    b_next = rotl32(l_j + ab_sum, ab_sum[4:0]);
  end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5 key schedule: accepts a 128-bit key, runs 3*max(T,C) mixing steps one
// per clock and exposes the resulting S table through a combinational read port.
module rc5_key_expand #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*B-1:0] key_in,
  input  logic           key_valid,
  output logic           key_ready,
  output logic           busy,
  output logic           s_valid,
  input  logic [4:0]     s_rd_addr,
  output logic [W-1:0]   s_rd_data
);

  import rc5_pkg::*;

  localparam int TW    = 2 * (R + 1);
  localparam int CW    = B / 4;
  localparam int KITER = 3 * ((TW > CW) ? TW : CW);
  localparam int IW    = $clog2(TW);
  localparam int JW    = $clog2(CW);
  localparam int KW    = $clog2(KITER);

  rc5_state_t state, state_nx;

  logic [W-1:0]  s_tab [TW];
  logic [W-1:0]  l_tab [CW];
  logic [W-1:0]  a_reg, b_reg;
  logic [W-1:0]  a_nx, b_nx;
  logic [IW-1:0] i_idx;
  logic [JW-1:0] j_idx;
  logic [KW-1:0] k_cnt;
  logic          accept;

  rc5_mix_step u_mix (
    .s_i    (s_tab[i_idx]),
    .l_j    (l_tab[j_idx]),
    .a      (a_reg),
    .b      (b_reg),
    .a_next (a_nx),
    .b_next (b_nx)
  );

  assign key_ready = (state != MIX);
  assign busy      = (state == MIX);
  assign s_valid   = (state == DONE);
  assign accept    = key_valid & key_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (key_valid) state_nx = MIX;
      MIX:     if (k_cnt == KW'(KITER - 1)) state_nx = DONE;
      DONE:    if (key_valid) state_nx = MIX;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // A new key always restarts from the magic-constant table, even from DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < TW; n++) s_tab[n] <= s_init(n);
      for (int n = 0; n < CW; n++) l_tab[n] <= '0;
      a_reg <= '0;
      b_reg <= '0;
      i_idx <= '0;
      j_idx <= '0;
      k_cnt <= '0;
    end else if (accept) begin
      for (int n = 0; n < TW; n++) s_tab[n] <= s_init(n);
      for (int n = 0; n < CW; n++) l_tab[n] <= key_in[32*n +: 32];
      a_reg <= '0;
      b_reg <= '0;
      i_idx <= '0;
      j_idx <= '0;
      k_cnt <= '0;
    end else if (state == MIX) begin
      s_tab[i_idx] <= a_nx;
      l_tab[j_idx] <= b_nx;
      a_reg        <= a_nx;
      b_reg        <= b_nx;
      i_idx        <= (i_idx == IW'(TW - 1)) ? '0 : i_idx + 1'b1;
      j_idx        <= (j_idx == JW'(CW - 1)) ? '0 : j_idx + 1'b1;
      k_cnt        <= k_cnt + 1'b1;
    end
  end

  always_comb begin
    s_rd_data = '0;
    if (s_rd_addr < 5'(TW)) s_rd_data = s_tab[s_rd_addr];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand: a behavioural key schedule predicts each
// table, read-back tables are compared word by word and fed to an RC5 encrypt.
module tb_rc5_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, s_valid;
  logic [4:0]   s_rd_addr = '0;
  logic [31:0]  s_rd_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] rb [26];

  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;

  rc5_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .s_valid   (s_valid),
    .s_rd_addr (s_rd_addr),
    .s_rd_data (s_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [31:0] n);
    logic [4:0] s;
    s = n[4:0];
    if (s == 0) return x;
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  task automatic push_model(input logic [127:0] key);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    s[0] = P;
    for (int n = 1; n < 26; n++) s[n] = s[n-1] + Q;
    for (int n = 0; n < 4; n++) l[n] = key[32*n +: 32];
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      a = rol(s[i] + a + b, 3);
      s[i] = a;
      b = rol(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int n = 0; n < 26; n++) exp_q.push_back(s[n]);
  endtask

  task automatic encrypt(input logic [31:0] p0, input logic [31:0] p1,
                         output logic [31:0] c0, output logic [31:0] c1);
    logic [31:0] a, b;
    a = p0 + rb[0];
    b = p1 + rb[1];
    for (int r = 1; r <= 12; r++) begin
      a = rol(a ^ b, b) + rb[2*r];
      b = rol(b ^ a, a) + rb[2*r+1];
    end
    c0 = a;
    c1 = b;
  endtask

  task automatic accept_key(input logic [127:0] key, input bit push);
    int n;
    n = 0;
    while (!key_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_accept", key_ready, 1'b1);
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    if (push) push_model(key);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("accept_svalid", s_valid, 1'b0);
  endtask

  // Starts right after the accept sample; optionally drives a second key mid-MIX.
  task automatic wait_done(input bit intrude, input logic [127:0] key2);
    int n, busy_n;
    n = 0; busy_n = 0;
    while (!s_valid && n < 200) begin
      if (busy && !key_ready) busy_n++;
      if (intrude) begin
        key_in    = key2;
        key_valid = (n >= 10 && n <= 40);
        if (n == 20) check("intrude_key_ready", key_ready, 1'b0);
      end
      @(posedge clk); #1; n++;
    end
    key_valid = 1'b0;
    check("latency", n, 78);
    check("busy_cycles", busy_n, 78);
  endtask

  task automatic drain();
    for (int a = 0; a < 26; a++) begin
      s_rd_addr = 5'(a); #1;
      rb[a] = s_rd_data;
      if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
      else check($sformatf("S[%0d]", a), s_rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] c0, c1, sv;
    logic [127:0] kb, k2;

    // reset state and constant table
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_svalid", s_valid, 1'b0);
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    sv = P;
    for (int a = 0; a < 26; a++) begin
      s_rd_addr = 5'(a); #1;
      check($sformatf("rst_S[%0d]", a), s_rd_data, sv);
      sv = sv + Q;
    end
    s_rd_addr = 5'd1; #1; check("rst_S1_lit", s_rd_data, 32'h5618CB1C);
    s_rd_addr = 5'd2; #1; check("rst_S2_lit", s_rd_data, 32'hF45044D5);
    s_rd_addr = 5'd26; #1; check("addr26_zero", s_rd_data, 32'h0);
    s_rd_addr = 5'd31; #1; check("addr31_zero", s_rd_data, 32'h0);

    // zero key, then encrypt with the read-back table (published vector,
    // bytes 21 A5 DB EE 15 4B 8F 6D taken as little-endian words)
    accept_key('0, 1'b1);
    wait_done(1'b0, '0);
    drain();
    encrypt(32'h0, 32'h0, c0, c1);
    check("enc0_A", c0, 32'hEEDBA521);
    check("enc0_B", c1, 32'h6D8F4B15);

    // second published vector; accepted straight from DONE
    kb = 128'h915F4619BE41B2516355A50110A9CE91;
    for (int n = 0; n < 16; n++) k2[8*n +: 8] = kb[127-8*n -: 8];
    check("done_before_reload", s_valid, 1'b1);
    accept_key(k2, 1'b1);
    wait_done(1'b0, '0);
    drain();
    encrypt(32'hEEDBA521, 32'h6D8F4B15, c0, c1);
    check("enc1_A", c0, 32'hAC13C0F7);
    check("enc1_B", c1, 32'h52892B5B);

    // random keys, each accepted from DONE
    for (int t = 0; t < 50; t++) begin
      accept_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_done(1'b0, '0);
      drain();
    end

    // second key offered during MIX must be ignored
    kb = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~kb;
    accept_key(kb, 1'b1);
    wait_done(1'b1, k2);
    drain();

    // async reset mid-MIX, then a fresh key
    accept_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_key_ready", key_ready, 1'b1);
    check("arst_svalid", s_valid, 1'b0);
    s_rd_addr = 5'd0; #1; check("arst_S0", s_rd_data, P);
    s_rd_addr = 5'd5; #1; check("arst_S5", s_rd_data, P + 32'd5 * Q);
    @(negedge clk); rst = 1'b1;
    accept_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_done(1'b0, '0);
    drain();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
